// File: rtl/pipeline_sched.sv
// Purpose : round-robin scheduler sharing one 4-lane summation pipeline among NREQ requesters.
// Latency : grant 1 cycle after req_valid; beats pass combinationally; rsp 1 cycle after pipe_done.
// Backpres: requester backpressured via req_ready; no grant while MAX_INFLIGHT packets are outstanding.
//
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_data/req_ready : per-requester beat handshake, 4 lanes of W bits each
//   pipe_in1..4/pipe_en          : beat towards the pipeline
//   pipe_done                    : pipeline completion pulse, one per packet
//   rsp_valid/rsp_id             : requester ID of the completed packet (registered)
//   gnt_id/busy/inflight         : status
//   err_underflow                : sticky, completion seen with no packet outstanding
module pipeline_sched #(
    parameter int NREQ         = 4,
    parameter int W            = 32,
    parameter int BEATS        = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*4*W-1:0]           req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [W-1:0]                  pipe_in1,
    output logic [W-1:0]                  pipe_in2,
    output logic [W-1:0]                  pipe_in3,
    output logic [W-1:0]                  pipe_in4,
    output logic                          pipe_en,
    input  logic                          pipe_done,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [$clog2(NREQ)-1:0]       gnt_id,
    output logic                          busy,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_underflow
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_INFLIGHT) + 1;
    localparam int AW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GW  = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDW-1:0]   r_gnt;
    logic [IDW-1:0]   r_ptr;        // first requester examined by the next scan
    logic [BW-1:0]    r_beat;
    logic [GW-1:0]    r_gap;
    logic [IDW-1:0]   r_fifo [MAX_INFLIGHT];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_inflight;
    logic             r_rsp_vld;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_err;

    logic             w_any;
    logic [IDW-1:0]   w_pick;
    logic             w_grant;
    logic             w_accept;
    logic             w_last;
    logic             w_pop;
    logic [4*W-1:0]   w_lanes;

    // Round-robin pick: walk offsets downwards so the smallest offset from r_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any  = 1'b1;
                w_pick = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_grant  = (r_state == S_IDLE) && w_any && (r_inflight < CW'(MAX_INFLIGHT));
    assign w_accept = (r_state == S_SEND) && req_valid[r_gnt];
    assign w_last   = w_accept && (r_beat == BW'(BEATS - 1));
    // Pop uses the pre-push occupancy, so a push into an empty FIFO cannot satisfy a same-cycle done.
    assign w_pop    = pipe_done && (r_inflight != '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_next_state = S_SEND;
            S_SEND: if (w_last)  w_next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            S_GAP:  if (r_gap == GW'(GAP_CYCLES - 1)) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt == IDW'(i)) w_lanes = req_data[i*4*W +: 4*W];
        end
        req_ready = '0;
        if (w_accept) req_ready[r_gnt] = 1'b1;
        pipe_en  = w_accept;
        pipe_in1 = w_accept ? w_lanes[0*W +: W] : '0;
        pipe_in2 = w_accept ? w_lanes[1*W +: W] : '0;
        pipe_in3 = w_accept ? w_lanes[2*W +: W] : '0;
        pipe_in4 = w_accept ? w_lanes[3*W +: W] : '0;
        busy     = (r_state != S_IDLE);
    end

    // Grant, beat and gap counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= '0;
            r_ptr  <= '0;
            r_beat <= '0;
            r_gap  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt  <= w_pick;
                r_ptr  <= IDW'((int'(w_pick) + 1) % NREQ);
                r_beat <= '0;
            end else if (w_accept) begin
                r_beat <= w_last ? '0 : r_beat + BW'(1);
            end
            if (w_last) begin
                r_gap <= '0;
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap + GW'(1);
            end
        end
    end

    // Tag FIFO, credit count and response register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) r_fifo[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_last) begin
                r_fifo[r_wr_ptr] <= r_gnt;
                r_wr_ptr <= (r_wr_ptr == AW'(MAX_INFLIGHT - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(MAX_INFLIGHT - 1)) ? '0 : r_rd_ptr + AW'(1);
                r_rsp_id <= r_fifo[r_rd_ptr];
            end
            case ({w_last, w_pop})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_rsp_vld <= w_pop;
            if (pipe_done && (r_inflight == '0)) r_err <= 1'b1;
        end
    end

    assign gnt_id        = r_gnt;
    assign rsp_valid     = r_rsp_vld;
    assign rsp_id        = r_rsp_id;
    assign inflight      = r_inflight;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_pipeline_sched.sv
// Purpose : scoreboard bench for pipeline_sched (expected beats and response IDs queued at issue).
// Latency : monitors sample 1 time unit after each falling edge.
// Backpres: requester models hold each beat until req_ready is seen.
module tb_pipeline_sched;
    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int BEATS = 4;
    localparam int MAXI  = 4;
    localparam int GAP   = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*4*W-1:0] req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        pipe_in1, pipe_in2, pipe_in3, pipe_in4;
    logic                pipe_en;
    logic                pipe_done;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [1:0]          gnt_id;
    logic                busy;
    logic [2:0]          inflight;
    logic                err_underflow;

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    logic auto_en   = 1'b0;
    assign pipe_done = auto_done | man_done;

    always #5 clk = ~clk;

    pipeline_sched #(.NREQ(NREQ), .W(W), .BEATS(BEATS), .MAX_INFLIGHT(MAXI), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_in1(pipe_in1), .pipe_in2(pipe_in2), .pipe_in3(pipe_in3), .pipe_in4(pipe_in4),
        .pipe_en(pipe_en), .pipe_done(pipe_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .gnt_id(gnt_id), .busy(busy), .inflight(inflight), .err_underflow(err_underflow)
    );

    typedef struct {
        int             id;
        logic [4*W-1:0] lanes;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_rsp[$];
    int    exp_n[NREQ];
    int    total = 0;
    int    bad = 0;
    int    gap_idle = 0;

    // Requester model state
    int   want[NREQ];
    int   sent[NREQ];
    int   beat[NREQ];
    logic acc[NREQ];
    int   stall_id = -1;
    int   stall_at = 0;
    int   stall_len = 0;
    int   stall_arm = 0;

    function automatic logic [W-1:0] lane_val(input int id, input int pkt, input int b, input int l);
        return 32'h3DCC0000 + 32'(id * 4096 + pkt * 256 + b * 16 + l);
    endfunction

    function automatic logic [4*W-1:0] beat_val(input int id, input int pkt, input int b);
        return {lane_val(id, pkt, b, 3), lane_val(id, pkt, b, 2), lane_val(id, pkt, b, 1), lane_val(id, pkt, b, 0)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_pkt(input int id);
        beat_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.id    = id;
            e.lanes = beat_val(id, exp_n[id], b);
            exp_beats.push_back(e);
        end
        exp_rsp.push_back(id);
        exp_n[id]++;
    endtask

    // Requester driver: advances on beats accepted in the previous cycle, drives at the falling edge.
    always begin : drv
        bit v;
        int st_seen;
        int st_left;
        @(negedge clk);
        if (!rst) st_left = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rst) begin
                beat[i] = 0;
                sent[i] = want[i];
            end else if (acc[i]) begin
                beat[i]++;
                if (beat[i] == BEATS) begin
                    beat[i] = 0;
                    sent[i]++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            v = (sent[i] < want[i]);
            if (i == stall_id && v && beat[i] == stall_at && st_seen != stall_arm) begin
                st_seen = stall_arm;
                st_left = stall_len;
            end
            if (i == stall_id && st_left > 0) begin
                v = 1'b0;
                st_left--;
            end
            req_valid[i] = v;
            req_data[i*4*W +: 4*W] = beat_val(i, sent[i], beat[i]);
        end
        #1;
        for (int i = 0; i < NREQ; i++) acc[i] = req_ready[i];
    end

    // Pipeline model: in auto mode returns pipe_done a few cycles after each packet's last beat.
    always begin : pipe_model
        int due[$];
        int cyc;
        int pcnt;
        @(negedge clk);
        cyc++;
        auto_done = 1'b0;
        if (!rst) begin
            due.delete();
            pcnt = 0;
        end else if (due.size() > 0 && due[0] == cyc) begin
            void'(due.pop_front());
            auto_done = 1'b1;
        end
        #1;
        if (rst && pipe_en) begin
            pcnt++;
            if (pcnt == BEATS) begin
                pcnt = 0;
                if (auto_en) due.push_back(cyc + 3);
            end
        end
    end

    // Beat monitor
    always begin : beat_mon
        beat_t e;
        @(negedge clk);
        #1;
        if (busy && !pipe_en) gap_idle++;
        if (pipe_en) begin
            if (exp_beats.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_unexpected: gnt_id=%0d, no beat expected", gnt_id);
            end else begin
                e = exp_beats.pop_front();
                chk("beat_gnt_id", gnt_id, e.id);
                chk("beat_req_ready", req_ready, 1 << e.id);
                chk("beat_lanes", {pipe_in4, pipe_in3, pipe_in2, pipe_in1}, e.lanes);
            end
        end else begin
            chk("idle_req_ready", req_ready, 0);
            chk("idle_lanes", {pipe_in4, pipe_in3, pipe_in2, pipe_in1}, 0);
        end
    end

    // Response monitor
    always begin : rsp_mon
        int e;
        @(negedge clk);
        #1;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: rsp_id=%0d, none expected", rsp_id);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp_id", rsp_id, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_beats(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            if (exp_beats.size() == 0 && !busy) break;
            step(1);
        end
        if (k == 400) begin
            total++;
            bad++;
            $display("FAIL %s_beats_timeout: %0d beats outstanding, expected 0", nm, exp_beats.size());
        end
    endtask

    task automatic wait_rsp(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            if (exp_rsp.size() == 0 && inflight == 0) break;
            step(1);
        end
        if (k == 400) begin
            total++;
            bad++;
            $display("FAIL %s_rsp_timeout: %0d rsp outstanding, inflight=%0d, expected 0", nm, exp_rsp.size(), inflight);
        end
    endtask

    task automatic pulse_done();
        step(1);
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_pipe_en"}, pipe_en, 0);
        chk({nm, "_lanes"}, {pipe_in4, pipe_in3, pipe_in2, pipe_in1}, 0);
        chk({nm, "_rsp"}, {rsp_valid, rsp_id}, 0);
        chk({nm, "_gnt_id"}, gnt_id, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_inflight"}, inflight, 0);
        chk({nm, "_err"}, err_underflow, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0;
        int k;
        #3;
        chk_zero("reset");
        step(2);
        rst = 1'b1;
        step(2);

        // Single requester: grant one cycle after valid, 1 gap cycle, response ID 0
        g0 = gap_idle;
        want[0]++;
        push_pkt(0);
        @(negedge clk); #2;
        chk("t1_no_grant_yet", busy, 0);
        @(negedge clk); #2;
        chk("t1_granted", {busy, gnt_id, pipe_en}, {1'b1, 2'd0, 1'b1});
        step(1);
        wait_beats("t1");
        chk("t1_inflight", inflight, 1);
        chk("t1_gap_cycles", gap_idle - g0, 1);
        step(1);
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
        chk("t1_rsp_valid_next", rsp_valid, 1);
        chk("t1_inflight_after", inflight, 0);
        step(1);
        chk("t1_rsp_valid_drop", rsp_valid, 0);

        // Round-robin with all requesters continuously valid; scan resumes after last grant (0)
        auto_en = 1'b1;
        for (int i = 0; i < NREQ; i++) want[i] += 2;
        for (int p = 0; p < 8; p++) push_pkt((p + 1) % NREQ);
        wait_beats("t2");
        wait_rsp("t2");

        // Stall: requester 2 drops valid for 3 cycles after two accepted beats
        g0 = gap_idle;
        stall_id = 2;
        stall_at = 2;
        stall_len = 3;
        stall_arm++;
        want[2]++;
        push_pkt(2);
        wait_beats("t3");
        chk("t3_stall_plus_gap", gap_idle - g0, 4);
        wait_rsp("t3");
        stall_id = -1;

        // Credit limit: no completions, only four packets may issue
        auto_en = 1'b0;
        want[0] += 5;
        for (int p = 0; p < 5; p++) push_pkt(0);
        for (k = 0; k < 300; k++) begin
            if (exp_beats.size() == BEATS && !busy) break;
            step(1);
        end
        step(20);
        chk("t4_beats_left", exp_beats.size(), BEATS);
        chk("t4_inflight_full", inflight, 4);
        chk("t4_no_grant", busy, 0);
        pulse_done();
        wait_beats("t4");
        chk("t4_inflight_refill", inflight, 4);
        for (int p = 0; p < 4; p++) begin
            pulse_done();
            step(1);
        end
        wait_rsp("t4");

        // Push and pop in the same cycle with two packets outstanding
        want[1] += 2;
        push_pkt(1);
        push_pkt(1);
        wait_beats("t5a");
        chk("t5_inflight_two", inflight, 2);
        want[3]++;
        push_pkt(3);
        for (k = 0; k < 100; k++) begin
            @(negedge clk); #2;
            if (pipe_en && req_ready[3] && beat[3] == BEATS - 1) break;
        end
        if (k == 100) begin
            total++;
            bad++;
            $display("FAIL t5_last_beat_timeout: last beat of requester 3 not seen");
        end
        man_done = 1'b1;
        @(posedge clk); #2;
        man_done = 1'b0;
        chk("t5_inflight_same", inflight, 2);
        wait_beats("t5b");
        pulse_done();
        step(1);
        pulse_done();
        wait_rsp("t5");

        // Underflow: completion with nothing outstanding
        chk("t5_err_clear", err_underflow, 0);
        pulse_done();
        step(2);
        chk("t5_err_set", err_underflow, 1);
        chk("t5_inflight_zero", inflight, 0);
        step(5);
        chk("t5_err_sticky", err_underflow, 1);

        // Reset in the middle of a packet from requester 2
        auto_en = 1'b1;
        want[2]++;
        push_pkt(2);
        for (k = 0; k < 100; k++) begin
            @(negedge clk); #2;
            if (beat[2] == 2) break;
        end
        rst = 1'b0;
        #1;
        chk_zero("t6_reset");
        exp_beats.delete();
        exp_rsp.delete();
        @(posedge clk);
        @(negedge clk);
        step(1);
        rst = 1'b1;
        want[0]++;
        want[1]++;
        want[3]++;
        push_pkt(0);
        push_pkt(1);
        push_pkt(3);
        wait_beats("t6");
        wait_rsp("t6");
        chk("t6_err_after", err_underflow, 0);

        step(3);
        chk("end_queues_empty", exp_beats.size() + exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
